// File: rtl/band_peak.sv
// band_peak: per-frame peak magnitude of two FFT bin bands (A and B) with a 3-stage
// abs/magnitude/compare pipeline. Optional overflow screening via `define BAND_PEAK_OVF_EN.
module band_peak #(
    parameter int unsigned datlen    = 12,
    parameter int unsigned vlen      = 32,
    parameter int unsigned vlen_log2 = 5,
    parameter int unsigned a_lo      = 3,
    parameter int unsigned a_hi      = 6,
    parameter int unsigned b_lo      = 16,
    parameter int unsigned b_hi      = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*datlen-1:0]   ampl_f,
    input  logic                  out_nd,
    input  logic                  sof,
`ifdef BAND_PEAK_OVF_EN
    input  logic                  overflow,
    output logic                  ovf_err,
`endif
    output logic [datlen-1:0]     freq_a,
    output logic [datlen-1:0]     freq_b,
    output logic                  peak_vld,
    output logic                  sync_err
);

    localparam int unsigned FLUSH_CYC = 3;
    localparam logic [vlen_log2-1:0] LAST_BIN   = vlen_log2'(vlen - 1);
    localparam logic [1:0]           FLUSH_LAST = 2'(FLUSH_CYC - 1);

    // Band limits clipped to the frame; an empty or out-of-frame band never updates
    localparam int unsigned A_HI_C = (a_hi >= vlen) ? vlen - 1 : a_hi;
    localparam int unsigned B_HI_C = (b_hi >= vlen) ? vlen - 1 : b_hi;
    localparam bit A_EN = (a_lo <= a_hi) && (a_lo < vlen);
    localparam bit B_EN = (b_lo <= b_hi) && (b_lo < vlen);
    localparam logic [vlen_log2-1:0] A_LO_B = vlen_log2'(a_lo);
    localparam logic [vlen_log2-1:0] A_HI_B = vlen_log2'(A_HI_C);
    localparam logic [vlen_log2-1:0] B_LO_B = vlen_log2'(b_lo);
    localparam logic [vlen_log2-1:0] B_HI_B = vlen_log2'(B_HI_C);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_restart;
    logic                  w_load;
    logic                  w_frame_ok;
    logic [vlen_log2-1:0]  w_bin;

    logic [vlen_log2-1:0]  r_bin_cnt;
    logic [1:0]            r_flush_cnt;

    logic                  r_v1;
    logic [datlen-1:0]     r_abs_re;
    logic [datlen-1:0]     r_abs_im;
    logic [vlen_log2-1:0]  r_bin1;

    logic                  r_v2;
    logic [datlen-1:0]     r_mag2;
    logic [vlen_log2-1:0]  r_bin2;

    logic [datlen-1:0]     w_mx;
    logic [datlen-1:0]     w_mn;
    logic [datlen-1:0]     w_mag;
    logic                  w_in_a;
    logic                  w_in_b;

    logic [datlen-1:0]     r_max_a;
    logic [datlen-1:0]     r_max_b;
    logic [vlen_log2-1:0]  r_bin_a;
    logic [vlen_log2-1:0]  r_bin_b;

    // Two's-complement absolute value; the most negative input maps to 2^(datlen-1)
    function automatic logic [datlen-1:0] f_abs(input logic [datlen-1:0] x);
        return x[datlen-1] ? (~x + datlen'(1)) : x;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_start   = 1'b0;
        w_restart = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (out_nd && sof) begin
                    w_accept = 1'b1;
                    w_start  = 1'b1;
                    w_next   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (out_nd) begin
                    w_accept = 1'b1;
                    if (sof) begin
                        w_start   = 1'b1;
                        w_restart = 1'b1;
                    end else if (r_bin_cnt == LAST_BIN) begin
                        w_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_load = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_bin = w_start ? '0 : r_bin_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin_cnt   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_bin_cnt <= w_bin + vlen_log2'(1);
            end
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 2'd1;
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    // Stages 1 and 2; a frame (re)start squashes beats of the previous frame still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_abs_re <= '0;
            r_abs_im <= '0;
            r_bin1   <= '0;
            r_v2     <= 1'b0;
            r_mag2   <= '0;
            r_bin2   <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_abs_re <= f_abs(ampl_f[datlen-1:0]);
                r_abs_im <= f_abs(ampl_f[2*datlen-1:datlen]);
                r_bin1   <= w_bin;
            end
            r_v2 <= r_v1 && !w_start;
            if (r_v1) begin
                r_mag2 <= w_mag;
                r_bin2 <= r_bin1;
            end
        end
    end

    assign w_mx  = (r_abs_re >= r_abs_im) ? r_abs_re : r_abs_im;
    assign w_mn  = (r_abs_re >= r_abs_im) ? r_abs_im : r_abs_re;
    assign w_mag = w_mx + (w_mn >> 1);

    assign w_in_a = A_EN && (r_bin2 >= A_LO_B) && (r_bin2 <= A_HI_B);
    assign w_in_b = B_EN && (r_bin2 >= B_LO_B) && (r_bin2 <= B_HI_B);

    // Stage 3: strict greater-than keeps the lowest bin on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_a <= '0;
            r_max_b <= '0;
            r_bin_a <= '0;
            r_bin_b <= '0;
        end else if (w_start) begin
            r_max_a <= '0;
            r_max_b <= '0;
            r_bin_a <= '0;
            r_bin_b <= '0;
        end else if (r_v2) begin
            if (w_in_a && (r_mag2 > r_max_a)) begin
                r_max_a <= r_mag2;
                r_bin_a <= r_bin2;
            end
            if (w_in_b && (r_mag2 > r_max_b)) begin
                r_max_b <= r_mag2;
                r_bin_b <= r_bin2;
            end
        end
    end

`ifdef BAND_PEAK_OVF_EN
    logic r_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad   <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_bad <= overflow;
            end else if (w_accept && overflow) begin
                r_bad <= 1'b1;
            end
            if (w_accept && overflow) begin
                ovf_err <= 1'b1;
            end
        end
    end

    assign w_frame_ok = !r_bad;
`else
    assign w_frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_a   <= '0;
            freq_b   <= '0;
            peak_vld <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            peak_vld <= w_load && w_frame_ok;
            if (w_load && w_frame_ok) begin
                freq_a <= r_max_a;
                freq_b <= r_max_b;
            end
            if (w_restart) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_band_peak.sv
// Scoreboard bench for band_peak: expected peaks and pulse cycle are queued when a frame's
// last beat is driven and compared when peak_vld appears.
module tb_band_peak;

    logic        clk;
    logic        rst_n;
    logic [23:0] ampl_f;
    logic        out_nd;
    logic        sof;
    logic [11:0] freq_a;
    logic [11:0] freq_b;
    logic        peak_vld;
    logic        sync_err;
`ifdef BAND_PEAK_OVF_EN
    logic        overflow;
    logic        ovf_err;
`endif

    band_peak dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ampl_f   (ampl_f),
        .out_nd   (out_nd),
        .sof      (sof),
`ifdef BAND_PEAK_OVF_EN
        .overflow (overflow),
        .ovf_err  (ovf_err),
`endif
        .freq_a   (freq_a),
        .freq_b   (freq_b),
        .peak_vld (peak_vld),
        .sync_err (sync_err)
    );

    typedef struct {
        int fa;
        int fb;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] fr[32];
    int          cyc;
    int          last_cyc;
    int          n_total;
    int          n_bad;
    int          last_fa;
    int          last_fb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input logic [23:0] w);
        int re, im, ar, ai;
        re = $signed(w[11:0]);
        im = $signed(w[23:12]);
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        return (ar > ai) ? ar + ai / 2 : ai + ar / 2;
    endfunction

    function automatic int band_max(input int lo, input int hi);
        int best;
        best = 0;
        for (int k = lo; k <= hi; k++) begin
            if (mag_of(fr[k]) > best) best = mag_of(fr[k]);
        end
        return best;
    endfunction

    task automatic clear_frame();
        for (int k = 0; k < 32; k++) fr[k] = '0;
    endtask

    task automatic set_bin(input int idx, input int im, input int re);
        fr[idx] = {12'(im), 12'(re)};
    endtask

    task automatic send_beat(input logic s, input logic [23:0] d, input logic ovf);
        @(posedge clk);
        #1;
        out_nd = 1'b1;
        sof    = s;
        ampl_f = d;
`ifdef BAND_PEAK_OVF_EN
        overflow = ovf;
`else
        if (ovf) $display("overflow beat requested without overflow port");
`endif
        last_cyc = cyc;
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        out_nd = 1'b0;
        sof    = 1'b0;
        ampl_f = '0;
`ifdef BAND_PEAK_OVF_EN
        overflow = 1'b0;
`endif
    endtask

    task automatic send_frame(input int n, input int ovf_beat);
        for (int k = 0; k < n; k++) send_beat(k == 0, fr[k], k == ovf_beat);
    endtask

    task automatic push_exp();
        exp_t e;
        e.fa = band_max(3, 6);
        e.fb = band_max(16, 19);
        e.cyc = last_cyc + 4;
        last_fa = e.fa;
        last_fb = e.fb;
        sb.push_back(e);
    endtask

    task automatic good_frame();
        send_frame(32, -1);
        push_exp();
        go_idle();
        repeat (8) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        check("hold_a", freq_a, last_fa);
        check("hold_b", freq_b, last_fb);
    endtask

    // Pulse monitor: compare values and arrival cycle against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && peak_vld) begin
            if (sb.size() == 0) begin
                check("pulse_unexpected", 32'(peak_vld), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("freq_a", freq_a, e.fa);
                check("freq_b", freq_b, e.fb);
                check("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        last_fa = 0;
        last_fb = 0;
        rst_n   = 1'b0;
        out_nd  = 1'b0;
        sof     = 1'b0;
        ampl_f  = '0;
`ifdef BAND_PEAK_OVF_EN
        overflow = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_freq_a", freq_a, 0);
        check("rst_freq_b", freq_b, 0);
        check("rst_peak_vld", 32'(peak_vld), 0);
        check("rst_sync_err", 32'(sync_err), 0);
        rst_n = 1'b1;

        // Basic frame: expect 100 / 110
        clear_frame();
        set_bin(4, 0, 100);
        set_bin(17, -60, 80);
        good_frame();
        check("basic_a_const", freq_a, 100);
        check("basic_b_const", freq_b, 110);

        // Tie in band A: bin 3 and bin 5 both 50, lowest bin wins
        clear_frame();
        set_bin(3, 0, 50);
        set_bin(5, 50, 0);
        set_bin(18, -30, -40);
        good_frame();
        check("tie_bin", 32'(dut.r_bin_a), 3);
        check("tie_a_const", freq_a, 50);

        // Most negative components
        clear_frame();
        set_bin(5, -2048, -2048);
        good_frame();
        check("minneg_a_const", freq_a, 3072);

        // Random frames
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 32; k++) fr[k] = 24'($urandom());
            good_frame();
        end

        // Restart by sof at beat 10 of a partial frame
        check("pre_sync_err", 32'(sync_err), 0);
        clear_frame();
        set_bin(4, 0, 900);
        set_bin(5, 900, 0);
        send_frame(10, -1);
        clear_frame();
        set_bin(6, 0, 77);
        set_bin(19, 0, -33);
        good_frame();
        check("sync_err_set", 32'(sync_err), 1);
        check("restart_a_const", freq_a, 77);
        clear_frame();
        set_bin(16, 10, 10);
        good_frame();
        check("sync_err_sticky", 32'(sync_err), 1);

`ifdef BAND_PEAK_OVF_EN
        // Overflow on beat 7: frame dropped, outputs keep prior frame
        check("pre_ovf_err", 32'(ovf_err), 0);
        clear_frame();
        set_bin(4, 0, 500);
        set_bin(17, 0, 500);
        send_frame(32, 7);
        go_idle();
        repeat (8) @(posedge clk);
        #1;
        check("ovf_err_set", 32'(ovf_err), 1);
        check("ovf_hold_a", freq_a, last_fa);
        check("ovf_hold_b", freq_b, last_fb);
        clear_frame();
        set_bin(3, 0, 20);
        good_frame();
`endif

        // Reset at beat 20 aborts the frame; outputs stay 0 until the next full frame
        clear_frame();
        set_bin(4, 0, 300);
        set_bin(18, 0, 300);
        send_frame(20, -1);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        out_nd = 1'b0;
        sof    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_a", freq_a, 0);
        check("mid_rst_b", freq_b, 0);
        check("mid_rst_sync", 32'(sync_err), 0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_a", freq_a, 0);
        clear_frame();
        set_bin(6, -45, 12);
        set_bin(16, 200, -150);
        send_frame(32, -1);
        push_exp();
        check("pre_pulse_a", freq_a, 0);
        check("pre_pulse_b", freq_b, 0);
        go_idle();
        repeat (8) @(posedge clk);
        #1;
        check("sb_final", sb.size(), 0);
        check("final_a", freq_a, last_fa);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/band_peak.md
BAND_PEAK -- requirements
Module: band_peak

Interface
REQ-001 SHALL have parameter datlen, default 12, width of one FFT component and of each peak output.
REQ-002 SHALL have parameter vlen, default 32, FFT bins per frame.
REQ-003 SHALL have parameter vlen_log2, default 5, bin index width.
REQ-004 SHALL have parameters a_lo / a_hi, defaults 3 / 6, inclusive bin range of band A.
REQ-005 SHALL have parameters b_lo / b_hi, defaults 16 / 19, inclusive bin range of band B.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ampl_f, input, datlen*2, one FFT bin: upper datlen bits signed imag, lower datlen bits signed real.
REQ-009 SHALL have port out_nd, input, 1, ampl_f valid this cycle.
REQ-010 SHALL have port sof, input, 1, qualified by out_nd; marks bin 0 of a frame.
REQ-011 SHALL have port freq_a, output, datlen, peak magnitude in band A of the last completed frame.
REQ-012 SHALL have port freq_b, output, datlen, peak magnitude in band B of the last completed frame.
REQ-013 SHALL have port peak_vld, output, 1, one-cycle pulse when freq_a/freq_b update.
REQ-014 SHALL have port sync_err, output, 1, sticky flag for a frame restarted by sof mid-frame.

Function
REQ-015 SHALL compute magnitude as max(|re|,|im|) + (min(|re|,|im|) >> 1), unsigned datlen bits; |-2^(datlen-1)| = 2^(datlen-1); no overflow is possible.
REQ-016 SHALL pipeline as stage 1 abs, stage 2 magnitude, stage 3 band compare, each registered.
REQ-017 SHALL run FSM states IDLE, COLLECT and FLUSH.
REQ-018 SHALL, in IDLE, ignore beats without sof; an accepted beat with sof sets bin count to 0, clears both running maxima, and enters COLLECT.
REQ-019 SHALL, in COLLECT, increment the bin counter per accepted beat; after bin vlen-1 is accepted, enter FLUSH.
REQ-020 SHALL, in FLUSH, wait for the pipeline to drain; no beats are accepted and beats arriving in FLUSH are dropped.
REQ-021 SHALL, on leaving FLUSH, load freq_a/freq_b from the running maxima, pulse peak_vld and return to IDLE.
REQ-022 SHALL assert peak_vld exactly 4 cycles after the cycle carrying bin vlen-1.
REQ-023 SHALL update a running max only if the bin index is in range and its magnitude is strictly greater, so on a tie the lowest bin wins.
REQ-024 SHALL, for a band with lo > hi or lo >= vlen, report 0.
REQ-025 SHALL, on sof with out_nd in COLLECT, discard the partial frame, set sync_err, and restart at bin 0 using that beat.
REQ-026 SHALL make freq_a/freq_b hold between peak_vld pulses; a partial frame never changes them.

Reset
REQ-027 SHALL, while rst_n is low, asynchronously force FSM=IDLE, bin counter=0, running maxima=0, pipeline valids=0, freq_a=0, freq_b=0, peak_vld=0, sync_err=0.
REQ-028 SHALL, on reset mid-frame, discard the frame and produce no peak_vld; the first pulse follows a full frame begun with sof after reset release.
REQ-029 SHALL clear sync_err only by reset.

Configuration
REQ-030 SHALL, with BAND_PEAK_OVF_EN defined, add input overflow (1 bit, qualified by out_nd); any overflow beat in a frame marks it bad, a bad frame completes timing but gives no peak_vld and leaves outputs unchanged, and an added sticky output ovf_err (reset 0) is set.
REQ-031 SHALL, with BAND_PEAK_OVF_EN undefined, have neither the overflow nor the ovf_err port and treat every complete frame as good.

Verification
REQ-032 SHALL cover: reset, then 32 beats with sof on beat 0, bin 4 = {im=0, re=100}, bin 17 = {im=-60, re=80}, others 0 -> peak_vld 4 cycles after the last beat, freq_a=100, freq_b=110.
REQ-033 SHALL cover: bins 3 and 5 both magnitude 50, bin 3 first -> freq_a=50; a probe confirms bin 3 was selected.
REQ-034 SHALL cover: bin 5 = {im=-2048, re=-2048} -> freq_a=3072.
REQ-035 SHALL cover: sof at beat 10 of a frame, then 32 clean beats -> sync_err=1 and one peak_vld reflecting only the second frame.
REQ-036 SHALL cover: rst_n low at beat 20, then a full valid frame -> no pulse for the aborted frame, outputs 0 until the new frame's pulse.
REQ-037 SHALL cover, with BAND_PEAK_OVF_EN: overflow=1 on beat 7 -> no peak_vld, ovf_err=1, freq_a/freq_b unchanged from the prior frame.
